clk_gen_frac: RTL and testbench

Parametrised multi-channel fractional clock generator: the all-RTL successor to the single-output 50 MHz to 25.175644 MHz pixel PLL. From `refclk` it produces NUM_CLK independent clock-enable streams using phase accumulators. Each channel's increment can be reprogrammed at run time through a valid/ready port, and a PLL-style `locked` indication is provided. It sits at the top of the video/system clocking tree, and downstream logic runs on `refclk` gated by `clk_en`.

---
 rtl/clk_gen_pkg.sv | 21 ++
 rtl/clk_gen_acc.sv | 47 ++++
 rtl/clk_gen_frac.sv | 114 +++++++++++
 tb/tb_clk_gen_frac.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the fractional clock generator.
// Holds the lock FSM state type, the 25.175644 MHz default increment
// and the increment clamp used by every channel.
package clk_gen_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [31:0] DEFAULT_INC_25M = 32'd2162571353;

    // Limit an increment to half the accumulator range so a channel never
    // produces more than one tick every two refclk cycles.
    function automatic logic [63:0] inc_clamp(input logic [63:0] value, input int unsigned width);
        logic [63:0] limit;
        limit = 64'd1 << (width - 1);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/clk_gen_acc.sv
// One phase-accumulator channel: increment register with clamp, accumulator
// and registered carry. With CLKGEN_SQUARE_EN defined the accumulator MSB is
// exported for the square-wave output; otherwise no MSB port exists.
module clk_gen_acc
    import clk_gen_pkg::*;
#(
    parameter int                ACC_W     = 32,
    parameter logic [ACC_W-1:0]  INC_RESET = ACC_W'(DEFAULT_INC_25M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
`ifdef CLKGEN_SQUARE_EN
    output logic             msb,
`endif
    output logic             carry
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, inc};

    // Accumulate every cycle; a load restarts the phase from zero with the
    // new (clamped) increment and drops any carry in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            inc   <= ACC_W'(inc_clamp(64'(INC_RESET), ACC_W));
            carry <= 1'b0;
        end else if (load) begin
            acc   <= '0;
            inc   <= ACC_W'(inc_clamp(64'(load_inc), ACC_W));
            carry <= 1'b0;
        end else begin
            acc   <= sum[ACC_W-1:0];
            carry <= sum[ACC_W];
        end
    end

`ifdef CLKGEN_SQUARE_EN
    assign msb = acc[ACC_W-1];
`endif

endmodule

// File: rtl/clk_gen_frac.sv
// Multi-channel fractional clock-enable generator.
// Each channel is a phase accumulator; a lock FSM blanks all outputs for
// LOCK_CYCLES cycles after reset or after any channel is reprogrammed.
// Optional CLKGEN_SQUARE_EN adds the outclk square-wave port.
//
//   state  | meaning
//   SETTLE | counting settle cycles; outputs gated off, no reconfiguration
//   LOCKED | outputs live, cfg port ready
module clk_gen_frac
    import clk_gen_pkg::*;
#(
    parameter int                       NUM_CLK     = 2,
    parameter int                       ACC_W       = 32,
    parameter int                       LOCK_CYCLES = 16,
    parameter logic [NUM_CLK*ACC_W-1:0] INC_INIT    = {NUM_CLK{ACC_W'(DEFAULT_INC_25M)}},
    localparam int                      SEL_W       = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [SEL_W-1:0]   cfg_sel,
    input  logic [ACC_W-1:0]   cfg_inc,
    output logic [NUM_CLK-1:0] clk_en,
`ifdef CLKGEN_SQUARE_EN
    output logic [NUM_CLK-1:0] outclk,
`endif
    output logic               locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               sel_ok;
    logic [NUM_CLK-1:0] load;
    logic [NUM_CLK-1:0] carry;

    // Out-of-range selects are still accepted, just not applied.
    assign sel_ok = 32'(cfg_sel) < 32'(NUM_CLK);

    // State and settle counter registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= SETTLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, settle count and lock/ready decode.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        locked     = 1'b0;
        cfg_ready  = 1'b0;
        case (state)
            SETTLE: begin
                if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                    state_next = LOCKED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            LOCKED: begin
                locked    = 1'b1;
                cfg_ready = 1'b1;
                if (cfg_valid && sel_ok) begin
                    state_next = SETTLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = SETTLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef CLKGEN_SQUARE_EN
    logic [NUM_CLK-1:0] msb;
`endif

    for (genvar i = 0; i < NUM_CLK; i++) begin : g_ch
        assign load[i] = (state == LOCKED) && cfg_valid && sel_ok && (32'(cfg_sel) == 32'(i));

        clk_gen_acc #(
            .ACC_W     (ACC_W),
            .INC_RESET (INC_INIT[i*ACC_W +: ACC_W])
        ) u_acc (
            .clk      (refclk),
            .rst      (rst),
            .load     (load[i]),
            .load_inc (cfg_inc),
`ifdef CLKGEN_SQUARE_EN
            .msb      (msb[i]),
`endif
            .carry    (carry[i])
        );
    end

    // Carries seen while settling are discarded, not deferred.
    assign clk_en = carry & {NUM_CLK{locked}};

`ifdef CLKGEN_SQUARE_EN
    assign outclk = msb & {NUM_CLK{locked}};
`endif

endmodule

// File: tb/tb_clk_gen_frac.sv
// Directed bench for clk_gen_frac with three channels (so that a 2-bit
// cfg_sel can address a nonexistent channel). Expected clk_en patterns come
// from a per-channel period/phase model with hand-computed periods.
module tb_clk_gen_frac;

    localparam int NUM_CLK     = 3;
    localparam int ACC_W       = 32;
    localparam int LOCK_CYCLES = 16;

    logic         refclk    = 1'b0;
    logic         rst       = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [1:0]   cfg_sel   = 2'd0;
    logic [31:0]  cfg_inc   = 32'd0;
    logic [2:0]   clk_en;
`ifdef CLKGEN_SQUARE_EN
    logic [2:0]   outclk;
`endif
    logic         locked;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int period_m [NUM_CLK];
    int ref_m    [NUM_CLK];
    int n;

    always #5 refclk = ~refclk;

    clk_gen_frac #(
        .NUM_CLK     (NUM_CLK),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_sel   (cfg_sel),
        .cfg_inc   (cfg_inc),
        .clk_en    (clk_en),
`ifdef CLKGEN_SQUARE_EN
        .outclk    (outclk),
`endif
        .locked    (locked)
    );

    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic exp_bit(input int i);
        if (period_m[i] == 0) return 1'b0;
        return ((cyc - ref_m[i]) % period_m[i]) == 0;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NUM_CLK; i++) begin
            period_m[i] = 2;   // INC_INIT 2162571353 clamps to 2^31
            ref_m[i]    = 0;
        end
    endtask

    task automatic settle(input string tag);
        for (int k = 0; k < LOCK_CYCLES; k++) begin
            check({tag, "_locked_low"}, 64'(locked), 64'd0);
            check({tag, "_ready_low"}, 64'(cfg_ready), 64'd0);
            check({tag, "_clk_en_off"}, 64'(clk_en), 64'd0);
`ifdef CLKGEN_SQUARE_EN
            check({tag, "_outclk_off"}, 64'(outclk), 64'd0);
`endif
            tick();
        end
    endtask

    task automatic check_window(input int cycles, input string tag);
        for (int k = 0; k < cycles; k++) begin
            check({tag, "_locked"}, 64'(locked), 64'd1);
            check({tag, "_ready"}, 64'(cfg_ready), 64'd1);
            for (int i = 0; i < NUM_CLK; i++)
                check({tag, "_clk_en"}, 64'(clk_en[i]), 64'(exp_bit(i)));
            tick();
        end
    endtask

    task automatic do_cfg(input logic [1:0] sel, input logic [31:0] inc, input int period);
        check("cfg_ready_before_hs", 64'(cfg_ready), 64'd1);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_inc   = inc;
        tick();
        cfg_valid = 1'b0;
        period_m[sel] = period;
        ref_m[sel]    = cyc;
    endtask

    initial begin
        reset_model();
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;

        // Power-on settle: low through cycle 15, live from cycle 16.
        settle("por");
`ifdef CLKGEN_SQUARE_EN
        check("por_outclk_c16", 64'(outclk), 64'd0);
        tick();
        check("por_outclk_c17", 64'(outclk), 64'h7);
        tick();
        check("por_outclk_c18", 64'(outclk), 64'd0);
`endif
        check_window(4, "por");

        // ch0 at 2^31: exactly 50 pulses in 100 locked cycles.
        do_cfg(2'd0, 32'h8000_0000, 2);
        settle("hs0");
        n = 0;
        for (int k = 0; k < 100; k++) begin
            n += int'(clk_en[0]);
            tick();
        end
        check("ch0_half_rate_count", 64'(n), 64'd50);

        // ch1 at 2^30: period 4, ch0/ch2 phase untouched.
        do_cfg(2'd1, 32'h4000_0000, 4);
        settle("hs1");
        check_window(8, "ch1_quarter");

        // ch2 at all-ones clamps to 2^31: period 2, not every cycle.
        do_cfg(2'd2, 32'hFFFF_FFFF, 2);
        settle("hs2");
        check_window(8, "ch2_clamp");

        // ch1 stopped with inc 0.
        do_cfg(2'd1, 32'h0000_0000, 0);
        settle("hs3");
        check_window(40, "ch1_stopped");

        // Nonexistent channel 3: accepted, discarded, lock kept.
        check("bad_sel_ready", 64'(cfg_ready), 64'd1);
        cfg_valid = 1'b1;
        cfg_sel   = 2'd3;
        cfg_inc   = 32'h4000_0000;
        tick();
        cfg_valid = 1'b0;
        check_window(8, "bad_sel");

        // Requests during SETTLE are ignored rather than queued.
        do_cfg(2'd1, 32'h4000_0000, 4);
        cfg_valid = 1'b1;
        cfg_sel   = 2'd0;
        cfg_inc   = 32'h4000_0000;
        for (int k = 0; k < LOCK_CYCLES; k++) begin
            check("busy_locked_low", 64'(locked), 64'd0);
            check("busy_ready_low", 64'(cfg_ready), 64'd0);
            tick();
        end
        cfg_valid = 1'b0;
        check_window(8, "busy_ignored");

        // One-cycle reset while locked restores INC_INIT on every channel.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
        reset_model();
        settle("rst");
        check_window(4, "rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
